data_mem_responder: RTL

Handshaked data-memory responder: the memory side of the CPU's data-memory port. It accepts one load/store request at a time and models a configurable number of wait states. It stores data in a little-endian byte array and returns read data or an error flag through a response handshake. It replaces the ideal single-cycle data memory once the datapath is pipelined and stalls on memory.

---
 rtl/data_mem_responder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder: one outstanding load/store, fixed wait states,
// little-endian byte storage, and a response carrying read data or an error flag.
module data_mem_responder #(
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] address,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [63:0] write_data,
  input  logic [3:0]  xfer_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] read_data,
  output logic        err,
  output logic [1:0]  state_dbg
);

  // Handshakes: a request transfers on a rising edge with req_valid && req_ready,
  // a response on a rising edge with resp_valid && resp_ready; the opposite side
  // must hold its valid and payload stable until that transfer edge.

  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [7:0]  mem [DEPTH_BYTES];

  logic [AW-1:0] lat_addr;
  logic          lat_we;
  logic          lat_re;
  logic [63:0]   lat_wdata;
  logic [3:0]    lat_size;
  logic          lat_err;

  // Request validation, evaluated on the live request at accept time
  logic        size_legal;
  logic        misaligned;
  logic [64:0] end_addr;
  logic        out_of_range;
  logic        req_err;

  always_comb begin
    size_legal   = (xfer_size == 4'd1) || (xfer_size == 4'd2) ||
                   (xfer_size == 4'd4) || (xfer_size == 4'd8);
    misaligned   = |(address & {60'd0, xfer_size - 4'd1});
    end_addr     = {1'b0, address} + {61'd0, xfer_size};
    out_of_range = end_addr > 65'(DEPTH_BYTES);
    req_err      = !size_legal || misaligned || out_of_range ||
                   (write_enable && read_enable);
  end

  // With no wait states the commit happens on the accept edge, so it uses the live request
  logic [AW-1:0] c_addr;
  logic          c_we;
  logic          c_re;
  logic [63:0]   c_wdata;
  logic [3:0]    c_size;
  logic          c_err;
  logic          commit_fire;

  always_comb begin
    if (WAIT_STATES == 0) begin
      c_addr      = address[AW-1:0];
      c_we        = write_enable;
      c_re        = read_enable;
      c_wdata     = write_data;
      c_size      = xfer_size;
      c_err       = req_err;
      commit_fire = (state == S_IDLE) && req_valid;
    end else begin
      c_addr      = lat_addr;
      c_we        = lat_we;
      c_re        = lat_re;
      c_wdata     = lat_wdata;
      c_size      = lat_size;
      c_err       = lat_err;
      commit_fire = (state == S_WAIT) && (wait_cnt == 4'd0);
    end
  end

  logic [63:0] raw_rdata;
  logic [63:0] commit_rdata;

  always_comb begin
    raw_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < c_size) raw_rdata[8*i +: 8] = mem[c_addr + AW'(i)];
    end
    commit_rdata = (c_re && !c_err) ? raw_rdata : 64'd0;
  end

  // Storage is deliberately unreset; a store dropped by reset never reaches here
  always_ff @(posedge clk) begin
    if (reset && commit_fire && c_we && !c_err) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < c_size) mem[c_addr + AW'(i)] <= c_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      read_data <= 64'd0;
      err       <= 1'b0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_re    <= 1'b0;
      lat_wdata <= 64'd0;
      lat_size  <= 4'd0;
      lat_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_addr  <= address[AW-1:0];
            lat_we    <= write_enable;
            lat_re    <= read_enable;
            lat_wdata <= write_data;
            lat_size  <= xfer_size;
            lat_err   <= req_err;
            if (WAIT_STATES == 0) begin
              state     <= S_RESP;
              read_data <= commit_rdata;
              err       <= c_err;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= 4'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state     <= S_RESP;
            read_data <= commit_rdata;
            err       <= c_err;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state     <= S_IDLE;
            read_data <= 64'd0;
            err       <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign state_dbg  = state;

endmodule
